// File: rtl/cnn_pkg.sv
// Shared constants for the CNN post-processing stages.
package cnn_pkg;

    // valid_in / valid_out encodings
    localparam logic [1:0] VLD_NONE = 2'd0;
    localparam logic [1:0] VLD_A    = 2'd1;
    localparam logic [1:0] VLD_B    = 2'd2;
    localparam logic [1:0] VLD_EOF  = 2'd3;

    // Pooling reduction modes
    localparam int unsigned POOL_MAX = 0;
    localparam int unsigned POOL_AVG = 1;

endpackage

// File: rtl/relu_sat.sv
// Saturating ReLU: clamps a signed sample into [0, 2^(OUT_W-1)-1].
module relu_sat #(
    parameter int unsigned IN_W  = 20,
    parameter int unsigned OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  data_i,
    output logic        [OUT_W-1:0] data_o
);

    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W - 1)) - 1);

    // Negative -> 0, above the largest positive output -> saturate, else pass low bits
    always_comb begin
        if (data_i[IN_W-1]) begin
            data_o = '0;
        end else if (data_i > SAT_MAX) begin
            data_o = SAT_MAX[OUT_W-1:0];
        end else begin
            data_o = data_i[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/relu_pool_multi.sv
// Multi-channel ReLU + 1-D pooling stage: each channel reduces POOL_N
// consecutive samples to one result by max or truncating average.
module relu_pool_multi
    import cnn_pkg::*;
#(
    parameter int unsigned IN_W      = 20,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned POOL_N    = 4,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned POOL_MODE = POOL_MAX,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic                    dut_run,
    input  logic [1:0]              valid_in,
    input  logic [CH_W-1:0]         ch_in,
    input  logic signed [IN_W-1:0]  conv_in,
    output logic signed [OUT_W-1:0] pool_out,
    output logic [1:0]              valid_out,
    output logic [CH_W-1:0]         ch_out,
    output logic                    partial_drop
);

    localparam int unsigned LOG2N = $clog2(POOL_N);
    // Wide enough to hold POOL_N saturated samples summed without overflow
    localparam int unsigned ACC_W = OUT_W + LOG2N;
    localparam int unsigned CNT_W = LOG2N;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_N - 1);

    logic [OUT_W-1:0]  relu_val;
    logic [ACC_W-1:0]  relu_ext;
    logic              data_beat;
    logic              eof_beat;
    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] ch_busy;
    logic [ACC_W-1:0]  acc_upd [NUM_CH];

    logic signed [OUT_W-1:0] pool_q, pool_d;
    logic [1:0]              vld_q, vld_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic                    drop_q, drop_d;

    relu_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_relu (
        .data_i (conv_in),
        .data_o (relu_val)
    );

    assign relu_ext  = ACC_W'(relu_val);
    assign data_beat = dut_run && ((valid_in == VLD_A) || (valid_in == VLD_B));
    assign eof_beat  = dut_run && (valid_in == VLD_EOF);

    for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [ACC_W-1:0] acc_q, acc_d, acc_comb;
        logic             hit;

        // Out-of-range channel numbers match no lane and are dropped
        assign hit = data_beat && (ch_in == CH_W'(c));

        // Running reduction of this channel with the current sample
        always_comb begin
            if (POOL_MODE == POOL_AVG) begin
                acc_comb = acc_q + relu_ext;
            end else begin
                acc_comb = (relu_ext > acc_q) ? relu_ext : acc_q;
            end
        end

        // Window position and accumulator next-state
        always_comb begin
            cnt_d = cnt_q;
            acc_d = acc_q;
            if (eof_beat) begin
                cnt_d = '0;
            end else if (hit) begin
                acc_d = (cnt_q == '0) ? relu_ext : acc_comb;
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
        end

        // Per-channel state registers
        always_ff @(posedge clk or posedge reset_b) begin
            if (reset_b) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                acc_q <= acc_d;
            end
        end

        assign acc_upd[c] = acc_comb;
        assign ch_done[c] = hit && (cnt_q == CNT_LAST);
        assign ch_busy[c] = (cnt_q != '0);
    end

    // Output next-state: completed window, end-of-frame echo, or idle with held data
    always_comb begin
        pool_d = pool_q;
        vld_d  = VLD_NONE;
        ch_d   = ch_q;
        drop_d = drop_q;
        if (eof_beat) begin
            vld_d = VLD_EOF;
            if (|ch_busy) begin
                drop_d = 1'b1;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_done[i]) begin
                    vld_d  = valid_in;
                    ch_d   = CH_W'(i);
                    pool_d = (POOL_MODE == POOL_AVG) ? OUT_W'(acc_upd[i] >> LOG2N)
                                                     : acc_upd[i][OUT_W-1:0];
                end
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            pool_q <= '0;
            vld_q  <= VLD_NONE;
            ch_q   <= '0;
            drop_q <= 1'b0;
        end else begin
            pool_q <= pool_d;
            vld_q  <= vld_d;
            ch_q   <= ch_d;
            drop_q <= drop_d;
        end
    end

    assign pool_out     = pool_q;
    assign valid_out    = vld_q;
    assign ch_out       = ch_q;
    assign partial_drop = drop_q;

endmodule

// File: tb/tb_relu_pool_multi.sv
// Self-checking bench: one max-mode 3-channel instance and one average-mode
// single-channel instance, each with its own stimulus and expectation queue.
module tb_relu_pool_multi;
    import cnn_pkg::*;

    typedef struct {
        logic [1:0] vld;
        logic [1:0] ch;
        logic [7:0] pool;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              m_run = 1'b0;
    logic [1:0]        m_vld = VLD_NONE;
    logic [1:0]        m_ch = '0;
    logic signed [19:0] m_conv = '0;
    logic signed [7:0] m_po;
    logic [1:0]        m_vo;
    logic [1:0]        m_co;
    logic              m_drop;

    logic              a_run = 1'b0;
    logic [1:0]        a_vld = VLD_NONE;
    logic [0:0]        a_ch = '0;
    logic signed [19:0] a_conv = '0;
    logic signed [7:0] a_po;
    logic [1:0]        a_vo;
    logic [0:0]        a_co;
    logic              a_drop;

    exp_t q_max[$];
    exp_t q_avg[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    relu_pool_multi #(
        .IN_W(20), .OUT_W(8), .POOL_N(4), .NUM_CH(3), .POOL_MODE(POOL_MAX)
    ) u_max (
        .clk(clk), .reset_b(rst), .dut_run(m_run), .valid_in(m_vld), .ch_in(m_ch),
        .conv_in(m_conv), .pool_out(m_po), .valid_out(m_vo), .ch_out(m_co),
        .partial_drop(m_drop)
    );

    relu_pool_multi #(
        .IN_W(20), .OUT_W(8), .POOL_N(4), .NUM_CH(1), .POOL_MODE(POOL_AVG)
    ) u_avg (
        .clk(clk), .reset_b(rst), .dut_run(a_run), .valid_in(a_vld), .ch_in(a_ch),
        .conv_in(a_conv), .pool_out(a_po), .valid_out(a_vo), .ch_out(a_co),
        .partial_drop(a_drop)
    );

    // One cycle on the max instance; inputs return to idle afterwards
    task automatic m_step(input logic run, input logic [1:0] vld, input logic [1:0] ch,
                          input int conv);
        m_run  = run;
        m_vld  = vld;
        m_ch   = ch;
        m_conv = conv[19:0];
        @(posedge clk);
        #1;
        m_vld = VLD_NONE;
    endtask

    task automatic a_step(input logic run, input logic [1:0] vld, input logic ch, input int conv);
        a_run  = run;
        a_vld  = vld;
        a_ch   = ch;
        a_conv = conv[19:0];
        @(posedge clk);
        #1;
        a_vld = VLD_NONE;
    endtask

    task automatic test_reset;
        #12;
        n_tests += 7;
        if (m_po !== 8'sd0) begin n_fail++; $display("FAIL reset_m_pool: got %0d want 0", m_po); end
        if (m_vo !== 2'd0) begin n_fail++; $display("FAIL reset_m_valid: got %0d want 0", m_vo); end
        if (m_co !== 2'd0) begin n_fail++; $display("FAIL reset_m_ch: got %0d want 0", m_co); end
        if (m_drop !== 1'b0) begin n_fail++; $display("FAIL reset_m_drop: got %0d want 0", m_drop); end
        if (a_po !== 8'sd0) begin n_fail++; $display("FAIL reset_a_pool: got %0d want 0", a_po); end
        if (a_vo !== 2'd0) begin n_fail++; $display("FAIL reset_a_valid: got %0d want 0", a_vo); end
        if (a_drop !== 1'b0) begin n_fail++; $display("FAIL reset_a_drop: got %0d want 0", a_drop); end
        rst = 1'b0;
    endtask

    task automatic test_max_single;
        int conv[4];
        conv = '{5, -3, 200, 17};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q_max.push_back(exp_t'{VLD_A, 2'd0, 8'd127});
            m_step(1'b1, VLD_A, 2'd0, conv[i]);
            n_tests++;
            if (q_max.size() != 0) begin
                e = q_max.pop_front();
                if (m_vo !== e.vld || m_co !== e.ch || m_po !== e.pool) begin
                    n_fail++;
                    $display("FAIL max_single[%0d]: got vld=%0d ch=%0d pool=%0d want vld=%0d ch=%0d pool=%0d",
                             i, m_vo, m_co, m_po, e.vld, e.ch, e.pool);
                end
            end else if (m_vo !== VLD_NONE) begin
                n_fail++;
                $display("FAIL max_single[%0d]: got vld=%0d want 0", i, m_vo);
            end
        end
    endtask

    task automatic test_avg;
        int conv[9];
        int tag[9];
        int ch[9];
        conv = '{10, 20, 30, 41, -5, 300, 100, 0, 3};
        tag  = '{1, 2, 1, 2, 1, 1, 1, 1, 1};
        ch   = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 9; i++) begin
            if (i == 3) q_avg.push_back(exp_t'{VLD_B, 2'd0, 8'd25});
            if (i == 8) q_avg.push_back(exp_t'{VLD_A, 2'd0, 8'd32});
            a_step(1'b1, tag[i][1:0], ch[i][0], conv[i]);
            n_tests++;
            if (q_avg.size() != 0) begin
                e = q_avg.pop_front();
                if (a_vo !== e.vld || a_co !== e.ch[0] || a_po !== e.pool) begin
                    n_fail++;
                    $display("FAIL avg[%0d]: got vld=%0d ch=%0d pool=%0d want vld=%0d ch=%0d pool=%0d",
                             i, a_vo, a_co, a_po, e.vld, e.ch, e.pool);
                end
            end else if (a_vo !== VLD_NONE) begin
                n_fail++;
                $display("FAIL avg[%0d]: got vld=%0d want 0", i, a_vo);
            end
        end
    endtask

    task automatic test_interleave;
        int conv[8];
        conv = '{1, 9, 2, 8, 3, 7, 4, 6};
        for (int i = 0; i < 8; i++) begin
            if (i == 6) q_max.push_back(exp_t'{VLD_B, 2'd0, 8'd4});
            if (i == 7) q_max.push_back(exp_t'{VLD_A, 2'd1, 8'd9});
            m_step(1'b1, (i % 2 == 0) ? VLD_B : VLD_A, (i % 2 == 0) ? 2'd0 : 2'd1, conv[i]);
            n_tests++;
            if (q_max.size() != 0) begin
                e = q_max.pop_front();
                if (m_vo !== e.vld || m_co !== e.ch || m_po !== e.pool) begin
                    n_fail++;
                    $display("FAIL interleave[%0d]: got vld=%0d ch=%0d pool=%0d want vld=%0d ch=%0d pool=%0d",
                             i, m_vo, m_co, m_po, e.vld, e.ch, e.pool);
                end
            end else if (m_vo !== VLD_NONE) begin
                n_fail++;
                $display("FAIL interleave[%0d]: got vld=%0d want 0", i, m_vo);
            end
        end
    endtask

    task automatic test_eof;
        int conv[12];
        int tag[12];
        int ch[12];
        // ch0 and ch1 partial, EOF, then fresh windows on both channels
        conv = '{50, 100, 60, 0, 6, 6, 6, 6, 1, 2, 3, 1};
        tag  = '{1, 2, 1, 3, 1, 1, 1, 1, 2, 2, 2, 2};
        ch   = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 12; i++) begin
            if (i == 3) q_max.push_back(exp_t'{VLD_EOF, 2'd1, 8'd9});
            if (i == 7) q_max.push_back(exp_t'{VLD_A, 2'd0, 8'd6});
            if (i == 11) q_max.push_back(exp_t'{VLD_B, 2'd1, 8'd3});
            m_step(1'b1, tag[i][1:0], ch[i][1:0], conv[i]);
            n_tests++;
            if (q_max.size() != 0) begin
                e = q_max.pop_front();
                if (m_vo !== e.vld || m_co !== e.ch || m_po !== e.pool) begin
                    n_fail++;
                    $display("FAIL eof[%0d]: got vld=%0d ch=%0d pool=%0d want vld=%0d ch=%0d pool=%0d",
                             i, m_vo, m_co, m_po, e.vld, e.ch, e.pool);
                end
            end else if (m_vo !== VLD_NONE) begin
                n_fail++;
                $display("FAIL eof[%0d]: got vld=%0d want 0", i, m_vo);
            end
            if (i == 2) begin
                n_tests++;
                if (m_drop !== 1'b0) begin n_fail++; $display("FAIL eof_drop_early: got %0d want 0", m_drop); end
            end
            if (i == 3 || i == 11) begin
                n_tests++;
                if (m_drop !== 1'b1) begin n_fail++; $display("FAIL eof_drop[%0d]: got %0d want 1", i, m_drop); end
            end
        end
        // EOF on the average instance with no window open: echo only, no drop
        q_avg.push_back(exp_t'{VLD_EOF, 2'd0, 8'd32});
        a_step(1'b1, VLD_EOF, 1'b0, 0);
        n_tests += 2;
        e = q_avg.pop_front();
        if (a_vo !== e.vld || a_co !== e.ch[0] || a_po !== e.pool) begin
            n_fail++;
            $display("FAIL eof_avg: got vld=%0d ch=%0d pool=%0d want vld=%0d ch=%0d pool=%0d",
                     a_vo, a_co, a_po, e.vld, e.ch, e.pool);
        end
        if (a_drop !== 1'b0) begin n_fail++; $display("FAIL eof_avg_drop: got %0d want 0", a_drop); end
    endtask

    task automatic test_hold;
        int run[10];
        int tag[10];
        int ch[10];
        int conv[10];
        run  = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
        tag  = '{1, 1, 1, 1, 1, 1, 3, 1, 2, 2};
        ch   = '{0, 0, 0, 0, 0, 0, 0, 3, 0, 0};
        conv = '{10, 70, 100, 100, 100, 100, 0, 120, 30, 20};
        for (int i = 0; i < 10; i++) begin
            if (i == 9) q_max.push_back(exp_t'{VLD_B, 2'd0, 8'd70});
            m_step(run[i][0], tag[i][1:0], ch[i][1:0], conv[i]);
            n_tests++;
            if (q_max.size() != 0) begin
                e = q_max.pop_front();
                if (m_vo !== e.vld || m_co !== e.ch || m_po !== e.pool) begin
                    n_fail++;
                    $display("FAIL hold[%0d]: got vld=%0d ch=%0d pool=%0d want vld=%0d ch=%0d pool=%0d",
                             i, m_vo, m_co, m_po, e.vld, e.ch, e.pool);
                end
            end else if (m_vo !== VLD_NONE) begin
                n_fail++;
                $display("FAIL hold[%0d]: got vld=%0d want 0", i, m_vo);
            end
        end
    endtask

    task automatic test_reset_mid;
        int conv[4];
        m_step(1'b1, VLD_A, 2'd0, 100);
        m_step(1'b1, VLD_A, 2'd0, 90);
        #3 rst = 1'b1;
        #1;
        n_tests += 4;
        if (m_po !== 8'sd0) begin n_fail++; $display("FAIL rst_mid_pool: got %0d want 0", m_po); end
        if (m_drop !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drop: got %0d want 0", m_drop); end
        if (m_vo !== 2'd0) begin n_fail++; $display("FAIL rst_mid_valid: got %0d want 0", m_vo); end
        if (a_po !== 8'sd0) begin n_fail++; $display("FAIL rst_mid_a_pool: got %0d want 0", a_po); end
        #2 rst = 1'b0;
        conv = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q_max.push_back(exp_t'{VLD_A, 2'd0, 8'd1});
            m_step(1'b1, VLD_A, 2'd0, conv[i]);
            n_tests++;
            if (q_max.size() != 0) begin
                e = q_max.pop_front();
                if (m_vo !== e.vld || m_co !== e.ch || m_po !== e.pool) begin
                    n_fail++;
                    $display("FAIL rst_mid[%0d]: got vld=%0d ch=%0d pool=%0d want vld=%0d ch=%0d pool=%0d",
                             i, m_vo, m_co, m_po, e.vld, e.ch, e.pool);
                end
            end else if (m_vo !== VLD_NONE) begin
                n_fail++;
                $display("FAIL rst_mid[%0d]: got vld=%0d want 0", i, m_vo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_max_single();
        test_avg();
        test_interleave();
        test_eof();
        test_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
